// File: rtl/c64_kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 -> C64 key matrix bridge.
package c64_kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_OVR0   = 8'h00;
  localparam logic [7:0] SC_OVR1   = 8'hFF;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;

  // Bytes following E1 in the Pause make sequence (E1 14 77 E1 F0 14 F0 77).
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } kidx_t;

  typedef struct packed {
    logic  hit;
    kidx_t idx;
  } map_entry_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic map_entry_t key_at(input logic [2:0] a, input logic [2:0] b);
    map_entry_t e;
    e.hit   = 1'b1;
    e.idx.a = a;
    e.idx.b = b;
    return e;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input sync, clock-fall detect, 11-bit frame FSM and inactivity timeout.
module ps2_rx
  import c64_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]        clk_sync;
  logic [1:0]        data_sync;
  logic              clk_prev;
  logic              fall;
  logic              bit_in;
  rx_state_t         state, state_next;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              parity_ok;
  logic [TCNT_W-1:0] tcnt;
  logic              timeout;
  logic              shift_en, par_en, valid_next, err_next;

  assign fall    = clk_prev & ~clk_sync[1];
  assign bit_in  = data_sync[1];
  assign timeout = (state != RX_IDLE) && !fall && (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    valid_next = 1'b0;
    err_next   = 1'b0;
    if (timeout) begin
      state_next = RX_IDLE;
      err_next   = 1'b1;
    end else if (fall) begin
      unique case (state)
        RX_IDLE: begin
          if (!bit_in) state_next = RX_DATA;
          else         err_next   = 1'b1;
        end
        RX_DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_next = RX_PARITY;
        end
        RX_PARITY: begin
          par_en     = 1'b1;
          state_next = RX_STOP;
        end
        RX_STOP: begin
          state_next = RX_IDLE;
          if (bit_in && parity_ok) valid_next = 1'b1;
          else                     err_next   = 1'b1;
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_prev   <= 1'b1;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_ok  <= 1'b0;
      tcnt       <= '0;
      scan_valid <= 1'b0;
      scan_code  <= '0;
      frame_err  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
      // Counter only runs while a frame is open; any fall or return to idle restarts it.
      if (fall || state_next == RX_IDLE) tcnt <= '0;
      else                               tcnt <= tcnt + TCNT_W'(1);
      if (state == RX_IDLE) bit_cnt <= '0;
      else if (shift_en)    bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg     <= {bit_in, shreg[7:1]};
      if (par_en)   parity_ok <= ^{shreg, bit_in};
      scan_valid <= valid_next;
      frame_err  <= err_next;
      if (valid_next) scan_code <= shreg;
    end
  end

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 keyboard to emulated C64 8x8 key matrix (CIA1 port A drive -> port B sense).
// Optional RESTORE key on E0 7D when PS2_KEYMATRIX_RESTORE_EN is defined.
module ps2_keymatrix
  import c64_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic       dot_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] keyboard_ROW,
  output logic [7:0] keyboard_COL,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err,
  output logic       restore
);

  logic [7:0][7:0] matrix;
  logic            ext, brk;
  logic [2:0]      pause_cnt;
  map_entry_t      entry;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (dot_clk),
    .rst        (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .frame_err  (frame_err)
  );

  function automatic map_entry_t lookup(input logic [8:0] key);
    map_entry_t e;
    e = '0;
    case (key)
      9'h066: e = key_at(3'd0, 3'd0);  9'h05A: e = key_at(3'd0, 3'd1);
      9'h174: e = key_at(3'd0, 3'd2);  9'h083: e = key_at(3'd0, 3'd3);
      9'h005: e = key_at(3'd0, 3'd4);  9'h004: e = key_at(3'd0, 3'd5);
      9'h003: e = key_at(3'd0, 3'd6);  9'h172: e = key_at(3'd0, 3'd7);
      9'h026: e = key_at(3'd1, 3'd0);  9'h01D: e = key_at(3'd1, 3'd1);
      9'h01C: e = key_at(3'd1, 3'd2);  9'h025: e = key_at(3'd1, 3'd3);
      9'h01A: e = key_at(3'd1, 3'd4);  9'h01B: e = key_at(3'd1, 3'd5);
      9'h024: e = key_at(3'd1, 3'd6);  9'h012: e = key_at(3'd1, 3'd7);
      9'h02E: e = key_at(3'd2, 3'd0);  9'h02D: e = key_at(3'd2, 3'd1);
      9'h023: e = key_at(3'd2, 3'd2);  9'h036: e = key_at(3'd2, 3'd3);
      9'h021: e = key_at(3'd2, 3'd4);  9'h02B: e = key_at(3'd2, 3'd5);
      9'h02C: e = key_at(3'd2, 3'd6);  9'h022: e = key_at(3'd2, 3'd7);
      9'h03D: e = key_at(3'd3, 3'd0);  9'h035: e = key_at(3'd3, 3'd1);
      9'h034: e = key_at(3'd3, 3'd2);  9'h03E: e = key_at(3'd3, 3'd3);
      9'h032: e = key_at(3'd3, 3'd4);  9'h033: e = key_at(3'd3, 3'd5);
      9'h03C: e = key_at(3'd3, 3'd6);  9'h02A: e = key_at(3'd3, 3'd7);
      9'h046: e = key_at(3'd4, 3'd0);  9'h043: e = key_at(3'd4, 3'd1);
      9'h03B: e = key_at(3'd4, 3'd2);  9'h045: e = key_at(3'd4, 3'd3);
      9'h03A: e = key_at(3'd4, 3'd4);  9'h042: e = key_at(3'd4, 3'd5);
      9'h044: e = key_at(3'd4, 3'd6);  9'h031: e = key_at(3'd4, 3'd7);
      9'h04D: e = key_at(3'd5, 3'd1);  9'h04B: e = key_at(3'd5, 3'd2);
      9'h04E: e = key_at(3'd5, 3'd3);  9'h049: e = key_at(3'd5, 3'd4);
      9'h041: e = key_at(3'd5, 3'd7);  9'h16C: e = key_at(3'd6, 3'd3);
      9'h059: e = key_at(3'd6, 3'd4);  9'h055: e = key_at(3'd6, 3'd5);
      9'h04A: e = key_at(3'd6, 3'd7);  9'h016: e = key_at(3'd7, 3'd0);
      9'h01E: e = key_at(3'd7, 3'd3);  9'h029: e = key_at(3'd7, 3'd4);
      9'h014: e = key_at(3'd7, 3'd5);  9'h015: e = key_at(3'd7, 3'd6);
      9'h076: e = key_at(3'd7, 3'd7);
      default: e = '0;
    endcase
    return e;
  endfunction

  assign entry = lookup({ext, scan_code});

`ifdef PS2_KEYMATRIX_RESTORE_EN
  logic restore_q;
  assign restore = restore_q;
`else
  assign restore = 1'b0;
`endif

  always_ff @(posedge dot_clk or posedge reset) begin
    if (reset) begin
      matrix    <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      pause_cnt <= '0;
`ifdef PS2_KEYMATRIX_RESTORE_EN
      restore_q <= 1'b0;
`endif
    end else if (scan_valid) begin
      if (scan_code == SC_OVR0 || scan_code == SC_OVR1) begin
        matrix    <= '0;
        ext       <= 1'b0;
        brk       <= 1'b0;
        pause_cnt <= '0;
`ifdef PS2_KEYMATRIX_RESTORE_EN
        restore_q <= 1'b0;
`endif
      end else if (pause_cnt != '0) begin
        pause_cnt <= pause_cnt - 3'd1;
      end else if (scan_code == SC_BAT || scan_code == SC_ACK || scan_code == SC_RESEND) begin
        // Controller housekeeping bytes: leave any pending prefix intact.
      end else if (scan_code == SC_PAUSE) begin
        pause_cnt <= PAUSE_TAIL;
      end else if (scan_code == SC_EXT) begin
        ext <= 1'b1;
      end else if (scan_code == SC_BRK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (entry.hit) matrix[entry.idx.a][entry.idx.b] <= ~brk;
`ifdef PS2_KEYMATRIX_RESTORE_EN
        if (ext && scan_code == 8'h7D) restore_q <= ~brk;
`endif
      end
    end
  end

  always_comb begin
    keyboard_COL = '1;
    for (int unsigned b = 0; b < 8; b++) begin
      for (int unsigned a = 0; a < 8; a++) begin
        if (matrix[a][b] && !keyboard_ROW[a]) keyboard_COL[b] = 1'b0;
      end
    end
  end

endmodule
